sseg_capture: RTL

- Reverse path of the seven-segment display driver: samples a multiplexed, active-low segment bus and recovers the hex nibble shown on each digit.
- Filters transient patterns, flags glyphs that are not in the table, and keeps a per-digit shadow of the display.
- Sits next to the HEX display logic in the DE0-CV top level. The memory editor uses it to read back displayed values, and self-test uses it to check display data.

---
 rtl/sseg_capture.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sseg_capture.sv
// Seven-segment read-back: samples the multiplexed active-low segment bus,
// debounces each glyph and keeps a per-digit shadow of the displayed nibbles.
module sseg_capture #(
    parameter int NUM_DIGITS    = 6,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [2:0]              in_sel,
    input  logic [7:0]              in_seg_n,
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]   digit_lit,
    output logic                    upd,
    output logic [2:0]              upd_sel,
    output logic                    err,
    output logic [7:0]              err_cnt
);

    localparam logic [3:0] ND   = NUM_DIGITS[3:0];
    localparam logic [7:0] STAB = STABLE_CYCLES[7:0];

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        HELD
    } state_t;

    state_t     state, nxt_state;
    logic [2:0] cand_sel, nxt_sel;
    logic [6:0] cand_seg, nxt_seg;
    logic [7:0] count, nxt_cnt;
    logic       commit;
    logic [6:0] seg;
    logic       samp_ok;
    logic       same;
    logic       dec_known;
    logic       dec_blank;
    logic [3:0] dec_nib;

    assign seg     = ~in_seg_n[6:0];
    assign samp_ok = in_valid && ({1'b0, in_sel} < ND);
    assign same    = (state != IDLE) && (in_sel == cand_sel)
                     && (seg == cand_seg);

    // Glyph table: active-high segments g..a to nibble, blank or unknown.
    always_comb begin
        dec_known = 1'b1;
        dec_blank = 1'b0;
        dec_nib   = 4'h0;
        unique case (seg)
            7'h3F: dec_nib = 4'h0;
            7'h06: dec_nib = 4'h1;
            7'h5B: dec_nib = 4'h2;
            7'h4F: dec_nib = 4'h3;
            7'h66: dec_nib = 4'h4;
            7'h6D: dec_nib = 4'h5;
            7'h7D: dec_nib = 4'h6;
            7'h27: dec_nib = 4'h7;
            7'h7F: dec_nib = 4'h8;
            7'h6F: dec_nib = 4'h9;
            7'h77: dec_nib = 4'hA;
            7'h7C: dec_nib = 4'hB;
            7'h58: dec_nib = 4'hC;
            7'h5E: dec_nib = 4'hD;
            7'h79: dec_nib = 4'hE;
            7'h71: dec_nib = 4'hF;
            7'h00: begin
                dec_known = 1'b0;
                dec_blank = 1'b1;
            end
            default: dec_known = 1'b0;
        endcase
    end

    // Run tracking: a new pattern restarts the run, a repeat extends it.
    always_comb begin
        nxt_state = state;
        nxt_sel   = cand_sel;
        nxt_seg   = cand_seg;
        nxt_cnt   = count;
        commit    = 1'b0;
        if (samp_ok) begin
            if (!same) begin
                nxt_sel = in_sel;
                nxt_seg = seg;
                nxt_cnt = 8'd1;
                if (STABLE_CYCLES == 1) begin
                    nxt_state = HELD;
                    commit    = 1'b1;
                end else begin
                    nxt_state = TRACK;
                end
            end else if (state == TRACK) begin
                nxt_cnt = count + 8'd1;
                if (nxt_cnt == STAB) begin
                    nxt_state = HELD;
                    commit    = 1'b1;
                end
            end
        end
    end

    // Candidate and run-length registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cand_sel <= 3'd0;
            cand_seg <= 7'd0;
            count    <= 8'd0;
        end else begin
            state    <= nxt_state;
            cand_sel <= nxt_sel;
            cand_seg <= nxt_seg;
            count    <= nxt_cnt;
        end
    end

    // Shadow display and event outputs; only the committed digit changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_out   <= '0;
            digit_lit <= '0;
            upd       <= 1'b0;
            upd_sel   <= 3'd0;
            err       <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            upd <= 1'b0;
            err <= 1'b0;
            if (commit) begin
                if (dec_known || dec_blank) begin
                    upd     <= 1'b1;
                    upd_sel <= in_sel;
                    for (int k = 0; k < NUM_DIGITS; k++) begin
                        if (in_sel == k[2:0]) begin
                            digit_lit[k] <= dec_known;
                            if (dec_known)
                                hex_out[4*k +: 4] <= dec_nib;
                        end
                    end
                end else begin
                    err <= 1'b1;
                    if (err_cnt != 8'hFF)
                        err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end

endmodule
